// File: rtl/data_store_serializer_pkg.sv
// Shared encodings for the store serializer: FSM states, store size codes,
// byte-order codes and the size/alignment helpers used when a store is accepted.
package data_store_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic ORD_LE = 1'b0;
    localparam logic ORD_BE = 1'b1;

    // Number of bytes moved by a store; code 2'b11 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Big-endian stores left-justify the low bytes so the first byte sent is
    // always in [31:24]; little-endian stores send from [7:0] unchanged.
    function automatic logic [31:0] align_word(input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic        order);
        if (order == ORD_LE) begin
            align_word = data;
        end else begin
            case (size)
                SZ_BYTE: align_word = data << 24;
                SZ_HALF: align_word = data << 16;
                default: align_word = data;
            endcase
        end
    endfunction

endpackage

// File: rtl/data_store_serializer.sv
// Store serializer: writes a captured 32-bit word to a byte-wide memory port,
// one byte per beat accepted with MemReady, in little- or big-endian order.
module data_store_serializer
    import data_store_serializer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [31:0]       Data,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [1:0]        Size,
    input  logic              Order,
    input  logic              MemReady,
    output logic [7:0]        ByteOut,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic              Busy,
    output logic              Done
);

    // state | meaning
    // IDLE  | waiting for Start; captures the store when it arrives
    // WRITE | presenting bytes; advances on each MemReady beat
    // DONE  | one-cycle completion pulse, then back to IDLE

    state_t            state_q, state_d;
    logic [31:0]       shift_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              order_q;
    logic              load;
    logic              advance;

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        WrEn    = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                WrEn = 1'b1;
                Busy = 1'b1;
                if (MemReady) begin
                    advance = 1'b1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture on accepted Start, shift/count/step address per beat.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shift_q <= 32'd0;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            order_q <= ORD_LE;
        end else if (load) begin
            shift_q <= align_word(Data, Size, Order);
            cnt_q   <= size_bytes(Size);
            addr_q  <= Addr;
            order_q <= Order;
        end else if (advance) begin
            shift_q <= (order_q == ORD_BE) ? (shift_q << 8) : (shift_q >> 8);
            cnt_q   <= cnt_q - 3'd1;
            addr_q  <= addr_q + 1'b1;
        end
    end

    // The byte lane is only driven while a write is in progress.
    always_comb begin
        ByteOut = 8'd0;
        if (state_q == ST_WRITE) begin
            ByteOut = (order_q == ORD_BE) ? shift_q[31:24] : shift_q[7:0];
        end
    end

    assign Address = addr_q;

endmodule

// File: tb/tb_data_store_serializer.sv
// Bench for data_store_serializer: directed and random stores compared against
// a byte-list model built from the store rules, plus reset and round-trip cases.
module tb_data_store_serializer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] Data;
    logic [7:0]  Addr;
    logic [1:0]  Size;
    logic        Order;
    logic        MemReady;
    logic [7:0]  ByteOut;
    logic [7:0]  Address;
    logic        WrEn;
    logic        Busy;
    logic        Done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mem [0:255];

    data_store_serializer #(.ADDR_W(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Data     (Data),
        .Addr     (Addr),
        .Size     (Size),
        .Order    (Order),
        .MemReady (MemReady),
        .ByteOut  (ByteOut),
        .Address  (Address),
        .WrEn     (WrEn),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called just after a negedge; returns just after the negedge of the first
    // idle cycle, so consecutive calls exercise the single-cycle idle gap.
    // mode 0: always ready, 1: fixed stall pattern, 2: random ready.
    task automatic store(input logic [31:0] d, input logic [7:0] a, input logic [1:0] sz,
                         input logic ord, input int mode, input bit poke);
        int         n;
        int         idx;
        int         i;
        int         cyc;
        bit         mr;
        logic [7:0] eb [0:3];
        logic [7:0] ea [0:3];
        bit         pat [0:6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < 4; k++) begin
            idx   = ord ? (n - 1 - k) : k;
            eb[k] = (k < n) ? 8'((d >> (8 * idx)) & 32'hFF) : 8'h00;
            ea[k] = 8'((32'(a) + k) % 256);
        end

        Data = d; Addr = a; Size = sz; Order = ord; Start = 1'b1;
        MemReady = 1'($urandom);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        Data  = $urandom;
        Addr  = 8'($urandom);
        Size  = 2'($urandom);
        Order = 1'($urandom);

        i = 0;
        cyc = 0;
        while (i < n && cyc < 64) begin
            @(negedge Clock);
            chk("wren_write", WrEn, 1);
            chk("busy_write", Busy, 1);
            chk("done_write", Done, 0);
            chk("byte", ByteOut, eb[i]);
            chk("addr", Address, ea[i]);
            case (mode)
                0:       mr = 1'b1;
                1:       mr = (cyc < 7) ? pat[cyc] : 1'b1;
                default: mr = ($urandom_range(0, 99) < 60);
            endcase
            cyc++;
            MemReady = mr;
            Start = poke ? 1'($urandom) : 1'b0;
            if (mr) begin
                mem[Address] = ByteOut;
                i++;
            end
        end
        chk("beats_accepted", i, n);
        if (mode == 0) chk("latency", cyc, n);

        @(negedge Clock);
        chk("done_pulse", Done, 1);
        chk("wren_done", WrEn, 0);
        chk("busy_done", Busy, 1);
        Start = poke ? 1'b1 : 1'b0;
        MemReady = 1'($urandom);

        @(negedge Clock);
        chk("done_idle", Done, 0);
        chk("busy_idle", Busy, 0);
        chk("wren_idle", WrEn, 0);
        chk("byte_idle", ByteOut, 0);
        chk("addr_end", Address, 8'((32'(a) + n) % 256));
        Start = 1'b0;
    endtask

    initial begin
        logic [31:0] rt;

        Reset = 1'b0; Start = 1'b0; Data = 32'd0; Addr = 8'd0;
        Size = 2'b00; Order = 1'b0; MemReady = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;

        #12;
        chk("rst_byte", ByteOut, 0);
        chk("rst_addr", Address, 0);
        chk("rst_wren", WrEn, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        store(32'hA1B2C3D4, 8'h10, 2'b10, 1'b0, 0, 1'b0);
        store(32'hA1B2C3D4, 8'h10, 2'b10, 1'b1, 0, 1'b0);
        store(32'hA1B2C3D4, 8'h10, 2'b01, 1'b1, 0, 1'b0);
        store(32'hA1B2C3D4, 8'h10, 2'b01, 1'b0, 0, 1'b0);
        store(32'hA1B2C3D4, 8'h10, 2'b00, 1'b0, 0, 1'b0);
        store(32'hA1B2C3D4, 8'h10, 2'b00, 1'b1, 0, 1'b0);
        store(32'hA1B2C3D4, 8'hFE, 2'b10, 1'b0, 0, 1'b0);
        store(32'h01234567, 8'hFF, 2'b11, 1'b1, 0, 1'b0);
        store(32'hA1B2C3D4, 8'h20, 2'b10, 1'b0, 1, 1'b1);

        // Asynchronous reset after the second accepted byte of a word store.
        Data = 32'hDEADBEEF; Addr = 8'h30; Size = 2'b10; Order = 1'b0;
        Start = 1'b1; MemReady = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #3 Reset = 1'b0;
        #1;
        chk("midrst_byte", ByteOut, 0);
        chk("midrst_addr", Address, 0);
        chk("midrst_wren", WrEn, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        store(32'h5A6B7C8D, 8'h44, 2'b10, 1'b1, 2, 1'b0);

        store(32'h80FF017F, 8'h40, 2'b10, 1'b1, 1, 1'b1);
        rt = 32'd0;
        for (int k = 0; k < 4; k++) rt = {rt[23:0], mem[8'(8'h40 + k)]};
        chk("roundtrip_be", rt, 32'h80FF017F);

        store(32'h13579BDF, 8'hFD, 2'b10, 1'b0, 2, 1'b1);
        rt = 32'd0;
        for (int k = 0; k < 4; k++) rt = {mem[8'(8'hFD + k)], rt[31:8]};
        chk("roundtrip_le", rt, 32'h13579BDF);

        for (int r = 0; r < 40; r++) begin
            store($urandom, 8'($urandom), 2'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

endmodule
